vpg_mode_ctrl: RTL and testbench

VPG_MODE_CTRL -- requirements
Module: vpg_mode_ctrl

---
 rtl/vpg_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vpg_mode_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpg_mode_ctrl.sv
// Video pattern generator mode controller: sequences a timing-table reload
// through frame-aligned load, restart pulse and blanked settle frames.
module vpg_mode_ctrl #(
    parameter int unsigned PULSE_CYC     = 4,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned TIMEOUT_CYC   = 4194303
) (
    input  logic        clk_148_5,
    input  logic        reset,
    input  logic [3:0]  mode,
    input  logic        mode_change,
    input  logic        vs_in,
    output logic [11:0] h_disp,
    output logic [11:0] h_fporch,
    output logic [11:0] h_sync,
    output logic [11:0] h_bporch,
    output logic [11:0] v_disp,
    output logic [11:0] v_fporch,
    output logic [11:0] v_sync,
    output logic [11:0] v_bporch,
    output logic        hs_polarity,
    output logic        vs_polarity,
    output logic        frame_interlaced,
    output logic        timing_change,
    output logic        blank,
    output logic        busy,
    output logic        mode_err,
    output logic [3:0]  cur_mode
);

    typedef enum logic [2:0] {RUN, WAIT_VS, LOAD, PULSE, SETTLE} state_t;

    typedef struct packed {
        logic [11:0] hd, hf, hs, hb, vd, vf, vs, vb;
        logic        vpol, hpol;
    } timing_t;

    localparam logic [21:0] TIMEOUT     = 22'(TIMEOUT_CYC);
    localparam logic [2:0]  PULSE_LAST  = 3'(PULSE_CYC - 1);
    localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE_FRAMES - 1);

    function automatic timing_t mode_timing(input logic [3:0] m);
        timing_t t;
        case (m)
            4'd0:    t = '{12'd640, 12'd16, 12'd96, 12'd48, 12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0};
            4'd1:    t = '{12'd1280, 12'd110, 12'd40, 12'd220, 12'd720, 12'd5, 12'd5, 12'd20, 1'b1, 1'b1};
            default: t = '{12'd1920, 12'd88, 12'd44, 12'd148, 12'd1080, 12'd4, 12'd5, 12'd36, 1'b1, 1'b1};
        endcase
        return t;
    endfunction

    state_t      state, state_next;
    timing_t     tim;
    logic [3:0]  pending;
    logic [3:0]  eff_pending;
    logic        vs_d;
    logic [21:0] wait_cnt;
    logic [2:0]  pulse_cnt;
    logic [2:0]  frame_cnt;
    logic        supported, req_ok, req_bad;
    logic        frame_edge, frame_done;

    assign supported  = (mode < 4'd3);
    assign req_ok     = mode_change & supported;
    assign req_bad    = mode_change & ~supported;
    assign frame_edge = vs_polarity ? (vs_in & ~vs_d) : (~vs_in & vs_d);
    assign frame_done = frame_edge | (wait_cnt == TIMEOUT);
    // A request landing on the settle-exit clock still decides where we go next.
    assign eff_pending = req_ok ? mode : pending;

    assign h_disp           = tim.hd;
    assign h_fporch         = tim.hf;
    assign h_sync           = tim.hs;
    assign h_bporch         = tim.hb;
    assign v_disp           = tim.vd;
    assign v_fporch         = tim.vf;
    assign v_sync           = tim.vs;
    assign v_bporch         = tim.vb;
    assign vs_polarity      = tim.vpol;
    assign hs_polarity      = tim.hpol;
    assign frame_interlaced = 1'b0;

    always_ff @(posedge clk_148_5 or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (req_ok && mode != cur_mode) state_next = WAIT_VS;
            WAIT_VS: if (frame_done) state_next = LOAD;
            LOAD:    state_next = PULSE;
            PULSE:   if (pulse_cnt == PULSE_LAST) state_next = SETTLE;
            SETTLE:  if (frame_done && frame_cnt == SETTLE_LAST)
                         state_next = (eff_pending != cur_mode) ? WAIT_VS : RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_148_5 or posedge reset) begin
        if (reset) begin
            tim           <= mode_timing(4'd2);
            cur_mode      <= 4'd2;
            pending       <= 4'd2;
            timing_change <= 1'b0;
            blank         <= 1'b0;
            busy          <= 1'b0;
            mode_err      <= 1'b0;
            vs_d          <= 1'b0;
            wait_cnt      <= '0;
            pulse_cnt     <= '0;
            frame_cnt     <= '0;
        end else begin
            vs_d <= vs_in;
            if (req_bad) begin
                mode_err <= 1'b1;
            end else if (req_ok && (state != RUN || mode != cur_mode)) begin
                mode_err <= 1'b0;
                pending  <= mode;
            end
            case (state)
                RUN: if (state_next == WAIT_VS) begin
                    blank    <= 1'b1;
                    busy     <= 1'b1;
                    wait_cnt <= '0;
                end
                WAIT_VS: wait_cnt <= wait_cnt + 22'd1;
                LOAD: begin
                    tim           <= mode_timing(pending);
                    cur_mode      <= pending;
                    timing_change <= 1'b1;
                    pulse_cnt     <= '0;
                end
                PULSE: begin
                    pulse_cnt <= pulse_cnt + 3'd1;
                    if (state_next == SETTLE) begin
                        timing_change <= 1'b0;
                        frame_cnt     <= '0;
                        wait_cnt      <= '0;
                    end
                end
                SETTLE: begin
                    // Each frame, whether seen or timed out, restarts the per-frame timeout.
                    if (frame_done) begin
                        wait_cnt  <= '0;
                        frame_cnt <= frame_cnt + 3'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 22'd1;
                    end
                    if (state_next == RUN) begin
                        blank <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Self-checking bench for vpg_mode_ctrl: directed vector table, corner
// sequences and random traffic checked against a frame-level reference model.
module tb_vpg_mode_ctrl;

    localparam int PULSE  = 4;
    localparam int SETTLE = 2;
    localparam int TO     = 30;

    logic        clk_148_5 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mode = 4'd0;
    logic        mode_change = 1'b0;
    logic        vs_in = 1'b0;
    logic [11:0] h_disp, h_fporch, h_sync, h_bporch;
    logic [11:0] v_disp, v_fporch, v_sync, v_bporch;
    logic        hs_polarity, vs_polarity, frame_interlaced;
    logic        timing_change, blank, busy, mode_err;
    logic [3:0]  cur_mode;

    int errors = 0;
    int total  = 0;

    vpg_mode_ctrl #(
        .PULSE_CYC(PULSE),
        .SETTLE_FRAMES(SETTLE),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_148_5(clk_148_5),
        .reset(reset),
        .mode(mode),
        .mode_change(mode_change),
        .vs_in(vs_in),
        .h_disp(h_disp),
        .h_fporch(h_fporch),
        .h_sync(h_sync),
        .h_bporch(h_bporch),
        .v_disp(v_disp),
        .v_fporch(v_fporch),
        .v_sync(v_sync),
        .v_bporch(v_bporch),
        .hs_polarity(hs_polarity),
        .vs_polarity(vs_polarity),
        .frame_interlaced(frame_interlaced),
        .timing_change(timing_change),
        .blank(blank),
        .busy(busy),
        .mode_err(mode_err),
        .cur_mode(cur_mode)
    );

    always #5 clk_148_5 = ~clk_148_5;

    // hd, hf, hs, hb, vd, vf, vs, vb, vs_pol, hs_pol
    int tbl [0:2][0:9] = '{
        '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0},
        '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1},
        '{1920, 88, 44, 148, 1080, 4, 5, 36, 1, 1}
    };

    // Reference model: phase 0 idle, 1 awaiting frame, 2 reload clock, 3 pulse, 4 settling
    int   m_cur, m_pend, m_err, m_busy, m_tc, m_phase;
    int   quiet, pulse_left, frames_left;
    logic m_vs_prev;

    int   sq_cnt;
    logic sq_vs;

    task automatic model_reset();
        m_cur = 2; m_pend = 2; m_err = 0; m_busy = 0; m_tc = 0; m_phase = 0;
        quiet = 0; pulse_left = 0; frames_left = 0; m_vs_prev = 1'b0;
    endtask

    task automatic model_clock(input logic mc, input int m, input logic vs);
        int   old_pend;
        logic ok, bad, edge_seen, frame_end;
        old_pend  = m_pend;
        ok        = mc && (m <= 2);
        bad       = mc && (m > 2);
        edge_seen = (vs != m_vs_prev) && (int'(vs) == tbl[m_cur][8]);
        m_vs_prev = vs;
        frame_end = edge_seen || (quiet == TO);
        if (bad) m_err = 1;
        if (ok && m_phase != 0) begin
            m_pend = m;
            m_err  = 0;
        end
        case (m_phase)
            0: if (ok && m != m_cur) begin
                m_pend = m; m_err = 0; m_busy = 1; quiet = 0; m_phase = 1;
            end
            1: if (frame_end) m_phase = 2; else quiet++;
            2: begin
                m_cur = old_pend; m_tc = 1; pulse_left = PULSE; m_phase = 3;
            end
            3: begin
                pulse_left--;
                if (pulse_left == 0) begin
                    m_tc = 0; frames_left = SETTLE; quiet = 0; m_phase = 4;
                end
            end
            4: if (frame_end) begin
                frames_left--;
                quiet = 0;
                if (frames_left == 0) begin
                    if (m_pend != m_cur) m_phase = 1;
                    else begin m_phase = 0; m_busy = 0; end
                end
            end else quiet++;
            default: ;
        endcase
    endtask

    function automatic logic [97:0] exp_timing(input int m);
        return {12'(tbl[m][0]), 12'(tbl[m][1]), 12'(tbl[m][2]), 12'(tbl[m][3]),
                12'(tbl[m][4]), 12'(tbl[m][5]), 12'(tbl[m][6]), 12'(tbl[m][7]),
                1'(tbl[m][8]), 1'(tbl[m][9])};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic check_model();
        chk("timing", 128'({h_disp, h_fporch, h_sync, h_bporch, v_disp, v_fporch,
                             v_sync, v_bporch, vs_polarity, hs_polarity}),
            128'(exp_timing(m_cur)));
        chk("cur_mode", 128'(cur_mode), 128'(m_cur));
        chk("timing_change", 128'(timing_change), 128'(m_tc));
        chk("blank", 128'(blank), 128'(m_busy));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("mode_err", 128'(mode_err), 128'(m_err));
        chk("interlaced", 128'(frame_interlaced), 128'(0));
    endtask

    task automatic step(input logic mc, input logic [3:0] m, input logic vs);
        @(negedge clk_148_5);
        mode_change = mc;
        mode        = m;
        vs_in       = vs;
        @(posedge clk_148_5);
        model_clock(mc, int'(m), vs);
        #1;
        check_model();
    endtask

    task automatic step_sq(input logic mc, input logic [3:0] m, input int half);
        sq_cnt++;
        if (sq_cnt >= half) begin
            sq_cnt = 0;
            sq_vs  = ~sq_vs;
        end
        step(mc, m, sq_vs);
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        mode_change = 1'b0;
        mode        = 4'd0;
        vs_in       = 1'b0;
        sq_cnt      = 0;
        sq_vs       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_148_5);
        @(negedge clk_148_5);
        reset = 1'b0;
    endtask

    typedef struct {
        int mc, m, vs;
        int cur, blank, tc, err, hd;
    } vec_t;

    vec_t vecs [0:16];

    initial begin
        int   n;
        logic got;
        logic rv;
        int   half, cnt;

        // mc, mode, vs -> cur_mode, blank, timing_change, mode_err, h_disp
        vecs[0]  = '{0, 0, 0, 2, 0, 0, 0, 1920};
        vecs[1]  = '{1, 2, 0, 2, 0, 0, 0, 1920};
        vecs[2]  = '{1, 9, 0, 2, 0, 0, 1, 1920};
        vecs[3]  = '{0, 0, 0, 2, 0, 0, 1, 1920};
        vecs[4]  = '{1, 1, 0, 2, 1, 0, 0, 1920};
        vecs[5]  = '{0, 0, 0, 2, 1, 0, 0, 1920};
        vecs[6]  = '{0, 0, 1, 2, 1, 0, 0, 1920};
        vecs[7]  = '{0, 0, 1, 1, 1, 1, 0, 1280};
        vecs[8]  = '{0, 0, 1, 1, 1, 1, 0, 1280};
        vecs[9]  = '{0, 0, 1, 1, 1, 1, 0, 1280};
        vecs[10] = '{0, 0, 1, 1, 1, 1, 0, 1280};
        vecs[11] = '{0, 0, 1, 1, 1, 0, 0, 1280};
        vecs[12] = '{0, 0, 0, 1, 1, 0, 0, 1280};
        vecs[13] = '{0, 0, 1, 1, 1, 0, 0, 1280};
        vecs[14] = '{0, 0, 0, 1, 1, 0, 0, 1280};
        vecs[15] = '{0, 0, 1, 1, 0, 0, 0, 1280};
        vecs[16] = '{1, 0, 0, 1, 1, 0, 0, 1280};

        reset_dut();
        #1;
        check_model();

        for (int i = 0; i < 17; i++) begin
            step(1'(vecs[i].mc), 4'(vecs[i].m), 1'(vecs[i].vs));
            chk($sformatf("vec%0d_cur", i), 128'(cur_mode), 128'(vecs[i].cur));
            chk($sformatf("vec%0d_blank", i), 128'(blank), 128'(vecs[i].blank));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].blank));
            chk($sformatf("vec%0d_tc", i), 128'(timing_change), 128'(vecs[i].tc));
            chk($sformatf("vec%0d_err", i), 128'(mode_err), 128'(vecs[i].err));
            chk($sformatf("vec%0d_hdisp", i), 128'(h_disp), 128'(vecs[i].hd));
        end

        // Overwrite during settle: 1 then 0; mode 0 must follow without blank dropping.
        reset_dut();
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 300 && m_phase != 4; i++) step_sq(1'b0, 4'd0, 5);
        if (m_phase != 4) fail("settle_wait");
        step_sq(1'b1, 4'd1, 5);
        step_sq(1'b1, 4'd0, 5);
        for (int i = 0; i < 400; i++) begin
            step_sq(1'b0, 4'd0, 5);
            if (blank == 1'b0) break;
        end
        chk("blank_held_until_mode0", 128'(cur_mode), 128'(0));
        chk("blank_released", 128'(blank), 128'(0));
        chk("vs_pol_mode0", 128'(vs_polarity), 128'(0));
        chk("v_disp_mode0", 128'(v_disp), 128'(480));

        // Constant vs_in: reload and every settle frame end by timeout.
        reset_dut();
        step(1'b1, 4'd0, 1'b0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
            if (cur_mode == 4'd0) break;
        end
        chk("load_after_timeout", 128'(n), 128'(TO + 2));
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
            if (blank == 1'b0) break;
        end
        chk("run_after_settle_timeouts", 128'(n), 128'(PULSE + SETTLE * (TO + 1)));

        // Asynchronous reset in the middle of the restart pulse.
        reset_dut();
        step(1'b1, 4'd1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step_sq(1'b0, 4'd0, 5);
            if (timing_change) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("pulse_wait");
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tc", 128'(timing_change), 128'(0));
        chk("async_rst_hdisp", 128'(h_disp), 128'(1920));
        chk("async_rst_cur", 128'(cur_mode), 128'(2));
        chk("async_rst_blank", 128'(blank), 128'(0));
        model_reset();
        sq_cnt = 0;
        sq_vs  = 1'b0;
        vs_in  = 1'b0;
        repeat (2) @(posedge clk_148_5);
        @(negedge clk_148_5);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) step_sq(1'b0, 4'd0, 5);
        chk("abandoned_cur", 128'(cur_mode), 128'(2));
        chk("abandoned_busy", 128'(busy), 128'(0));

        // Random requests (including unsupported codes) over irregular frame timing.
        reset_dut();
        rv = 1'b0;
        half = 10;
        cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            cnt++;
            if (cnt >= half) begin
                cnt  = 0;
                rv   = ~rv;
                half = int'($urandom_range(2, 45));
            end
            step($urandom_range(0, 15) == 0, 4'($urandom_range(0, 3)), rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
